// File: rtl/branch_resolve_unit_if.sv
// Bundles the MEM-stage branch operands and the resolver outputs.
// The master modport drives the decode side; the slave modport is the resolver.
interface branch_resolve_unit_if #(
  parameter int N     = 64,
  parameter int CNT_W = 32
);
  logic             valid_M;
  logic             Uncond_M;
  logic             Branch_M;
  logic             CBNZ_M;
  logic             bCondCheck_M;
  logic [4:0]       Rt_B_cond;
  logic [N-1:0]     alu_result_M;
  logic             setFlags_M;
  logic [3:0]       flags_in;
  logic             PCSrc_M;
  logic             flush;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] resolved_cnt;

  modport master (
    output valid_M, Uncond_M, Branch_M, CBNZ_M, bCondCheck_M, Rt_B_cond,
           alu_result_M, setFlags_M, flags_in,
    input  PCSrc_M, flush, flags_q, taken_cnt, resolved_cnt
  );

  modport slave (
    input  valid_M, Uncond_M, Branch_M, CBNZ_M, bCondCheck_M, Rt_B_cond,
           alu_result_M, setFlags_M, flags_in,
    output PCSrc_M, flush, flags_q, taken_cnt, resolved_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolver: NZCV register, B/CBZ/CBNZ/B.cond decision, wrong-path shadow FSM.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int N            = 64,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
);

  typedef enum logic [0:0] {S_IDLE, S_SHADOW} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic [3:0]   r_flags;
  logic [N-1:0] w_alu;
  logic         w_zero;
  logic         w_cond;
  logic         w_taken;
  logic         w_eligible;
  logic         w_pcsrc;

  // Flags are {N,Z,C,V}; codes 14/15 are AL, bit 4 set is reserved and never taken.
  function automatic logic cond_true(input logic [4:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code[3:0])
      4'd0:    r = z;
      4'd1:    r = ~z;
      4'd2:    r = c;
      4'd3:    r = ~c;
      4'd4:    r = n;
      4'd5:    r = ~n;
      4'd6:    r = v;
      4'd7:    r = ~v;
      4'd8:    r = c & ~z;
      4'd9:    r = ~c | z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = ~z & (n == v);
      4'd13:   r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r & ~code[4];
  endfunction

  assign w_alu    = bus.alu_result_M;
  assign w_zero   = ~|w_alu;
  assign w_cond   = cond_true(bus.Rt_B_cond, r_flags);

  always_comb begin
    w_taken = 1'b0;
    if (bus.Uncond_M)
      w_taken = 1'b1;
    else if (bus.bCondCheck_M)
      w_taken = w_cond;
    else if (bus.Branch_M)
      w_taken = bus.CBNZ_M ^ w_zero;
  end

  assign w_eligible  = bus.valid_M & (r_state == S_IDLE) & ~reset;
  assign w_pcsrc     = w_eligible & w_taken;
  assign bus.PCSrc_M = w_pcsrc;
  assign bus.flush   = ~reset & (w_pcsrc | (r_state == S_SHADOW));
  assign bus.flags_q = r_flags;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pcsrc) begin
          w_state_nxt = S_SHADOW;
          w_cnt_nxt   = 4'(FLUSH_CYCLES);
        end
      end
      S_SHADOW: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_flags <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_eligible && bus.setFlags_M)
        r_flags <= bus.flags_in;
    end
  end

`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_resolved_cnt;
  logic             w_is_branch;

  assign w_is_branch = bus.Uncond_M | bus.bCondCheck_M | bus.Branch_M;

  // Both counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_cnt    <= '0;
      r_resolved_cnt <= '0;
    end else begin
      if (w_pcsrc && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + CNT_ONE;
      if (w_eligible && w_is_branch && (r_resolved_cnt != '1))
        r_resolved_cnt <= r_resolved_cnt + CNT_ONE;
    end
  end

  assign bus.taken_cnt    = r_taken_cnt;
  assign bus.resolved_cnt = r_resolved_cnt;
`else
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  assign bus.taken_cnt    = CNT_ZERO;
  assign bus.resolved_cnt = CNT_ZERO;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed branch sequences, a per-cycle reference model,
// and literal checks on the key cycles.
module tb_branch_resolve_unit;

  localparam int N      = 64;
  localparam int FLUSH  = 3;
  localparam int CNT_W  = 4;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] SAT_EXP = 4'hF;
`else
  localparam logic [CNT_W-1:0] SAT_EXP = 4'h0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  branch_resolve_unit_if #(.N(N), .CNT_W(CNT_W)) b ();

  branch_resolve_unit #(.N(N), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM-style condition evaluation: base test on code[3:1], code[0] inverts (except 15).
  function automatic bit cond_holds(input logic [4:0] c, input logic [3:0] f);
    bit n, z, cc, v, r;
    if (c[4]) return 1'b0;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cc;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cc && !z;
      3'd5:    r = (n == v);
      3'd6:    r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if (c[0] && (c[3:0] != 4'd15)) r = !r;
    return r;
  endfunction

  logic [3:0] m_flags;
  int         m_shadow;
  longint     m_taken;
  longint     m_resolved;

  initial begin
    m_flags    = 4'd0;
    m_shadow   = 0;
    m_taken    = 0;
    m_resolved = 0;
  end

  always @(negedge clk) begin
    bit elig, tk, is_br, e_pc, e_fl;
    longint e_tc, e_rc;
    elig  = b.valid_M && (m_shadow == 0) && !reset;
    is_br = b.Uncond_M || b.bCondCheck_M || b.Branch_M;
    if (b.Uncond_M)          tk = 1'b1;
    else if (b.bCondCheck_M) tk = cond_holds(b.Rt_B_cond, m_flags);
    else if (b.Branch_M)     tk = b.CBNZ_M ? (b.alu_result_M != 0) : (b.alu_result_M == 0);
    else                     tk = 1'b0;
    e_pc = elig && tk;
    e_fl = !reset && (e_pc || (m_shadow > 0));
`ifdef BRANCH_STATS_EN
    e_tc = m_taken;
    e_rc = m_resolved;
`else
    e_tc = 0;
    e_rc = 0;
`endif
    check("model_pcsrc", longint'(b.PCSrc_M), longint'(e_pc));
    check("model_flush", longint'(b.flush), longint'(e_fl));
    check("model_flags", longint'(b.flags_q), longint'(m_flags));
    check("model_taken_cnt", longint'(b.taken_cnt), e_tc);
    check("model_resolved_cnt", longint'(b.resolved_cnt), e_rc);
    if (reset) begin
      m_flags = 4'd0; m_shadow = 0; m_taken = 0; m_resolved = 0;
    end else begin
      if (m_shadow > 0) m_shadow--;
      else if (e_pc)    m_shadow = FLUSH;
      if (elig && b.setFlags_M) m_flags = b.flags_in;
      if (e_pc && m_taken < CNT_MAX) m_taken++;
      if (elig && is_br && m_resolved < CNT_MAX) m_resolved++;
    end
  end

  task automatic clear_in();
    b.valid_M = 0; b.Uncond_M = 0; b.Branch_M = 0; b.CBNZ_M = 0; b.bCondCheck_M = 0;
    b.Rt_B_cond = 5'd0; b.alu_result_M = '1; b.setFlags_M = 0; b.flags_in = 4'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      settle();
    end
  endtask

  task automatic do_flags(input logic [3:0] f);
    next_cycle();
    b.valid_M = 1; b.setFlags_M = 1; b.flags_in = f;
    settle();
  endtask

  task automatic do_bcond(input logic [4:0] c);
    next_cycle();
    b.valid_M = 1; b.bCondCheck_M = 1; b.Rt_B_cond = c;
    settle();
  endtask

  task automatic do_cb(input logic cbnz, input logic [N-1:0] alu);
    next_cycle();
    b.valid_M = 1; b.Branch_M = 1; b.CBNZ_M = cbnz; b.alu_result_M = alu;
    settle();
  endtask

  task automatic do_b();
    next_cycle();
    b.valid_M = 1; b.Uncond_M = 1;
    settle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clear_in();
    reset = 1'b1;
    idle(1);
    // A taken B presented under reset must not redirect or flush.
    next_cycle();
    b.valid_M = 1; b.Uncond_M = 1;
    settle();
    check("reset_pcsrc", longint'(b.PCSrc_M), 0);
    check("reset_flush", longint'(b.flush), 0);
    check("reset_flags", longint'(b.flags_q), 0);
    check("reset_taken_cnt", longint'(b.taken_cnt), 0);
    @(posedge clk); #1; reset = 1'b0; clear_in();
    settle();

    // 1) Z set, then EQ taken, NE not taken
    do_flags(4'b0100);
    do_bcond(5'd0);
    check("eq_taken", longint'(b.PCSrc_M), 1);
    check("eq_flush", longint'(b.flush), 1);
    idle(FLUSH);
    do_bcond(5'd1);
    check("ne_not_taken", longint'(b.PCSrc_M), 0);

    // 2) N=1, V=0
    do_flags(4'b1000);
    do_bcond(5'd10);
    check("ge_not_taken", longint'(b.PCSrc_M), 0);
    do_bcond(5'd11);
    check("lt_taken", longint'(b.PCSrc_M), 1);
    idle(FLUSH);
    do_bcond(5'd13);
    check("le_taken", longint'(b.PCSrc_M), 1);
    idle(FLUSH);
    do_bcond(5'h10);
    check("reserved_never", longint'(b.PCSrc_M), 0);
    do_bcond(5'd14);
    check("al_taken", longint'(b.PCSrc_M), 1);
    idle(FLUSH);

    // 3) CBZ / CBNZ
    do_cb(1'b0, 64'h0);
    check("cbz_zero_taken", longint'(b.PCSrc_M), 1);
    idle(FLUSH);
    do_cb(1'b1, 64'h1);
    check("cbnz_one_taken", longint'(b.PCSrc_M), 1);
    idle(FLUSH);
    do_cb(1'b0, 64'h8000_0000_0000_0000);
    check("cbz_msb_not_taken", longint'(b.PCSrc_M), 0);

    // 4) shadow squashes taken CBZ and flag writes for FLUSH cycles
    do_b();
    check("shadow_t_flush", longint'(b.flush), 1);
    for (int i = 1; i <= FLUSH; i++) begin
      next_cycle();
      b.valid_M = 1; b.Branch_M = 1; b.alu_result_M = '0;
      b.setFlags_M = 1; b.flags_in = 4'b1111;
      settle();
      check("shadow_squash_pcsrc", longint'(b.PCSrc_M), 0);
      check("shadow_flush_high", longint'(b.flush), 1);
    end
    do_cb(1'b0, 64'h0);
    check("post_shadow_cbz", longint'(b.PCSrc_M), 1);
    check("post_shadow_flags", longint'(b.flags_q), 4'b1000);
    idle(FLUSH);

    // 5) reset mid-shadow, then a taken B with a flag write in the same cycle
    do_b();
    next_cycle();
    reset = 1'b1;
    settle();
    check("reset_mid_flush", longint'(b.flush), 0);
    @(posedge clk); #1; reset = 1'b0; clear_in();
    settle();
    check("after_reset_flush", longint'(b.flush), 0);
    check("after_reset_flags", longint'(b.flags_q), 0);
    next_cycle();
    b.valid_M = 1; b.Uncond_M = 1; b.setFlags_M = 1; b.flags_in = 4'b0011;
    settle();
    check("b_after_reset", longint'(b.PCSrc_M), 1);
    next_cycle();
    settle();
    check("flag_write_in_taken_cycle", longint'(b.flags_q), 4'b0011);
    idle(FLUSH - 1);

    // 6) counter saturation
    for (int i = 0; i < 20; i++) begin
      do_b();
      idle(FLUSH);
    end
    check("taken_cnt_sat", longint'(b.taken_cnt), longint'(SAT_EXP));
    check("resolved_cnt_sat", longint'(b.resolved_cnt), longint'(SAT_EXP));

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
